// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the 2-write/2-read register file
//
// Purpose:
//   Default geometry, the zero-register address, and the write-request shape shared by
//   the register file top and its read ports.
// Contents:
//   DEFAULT_DATA_W  default register width in bits
//   DEFAULT_ADDR_W  default address width (depth = 2**ADDR_W)
//   ZERO_ADDR       address of the hardwired zero register
//   regfile_wreq_t  write request {we, waddr, wdata} at default widths
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int ZERO_ADDR      = 0;

  typedef struct packed {
    logic                      we;
    logic [DEFAULT_ADDR_W-1:0] waddr;
    logic [DEFAULT_DATA_W-1:0] wdata;
  } regfile_wreq_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port of the register file
//
// Purpose:
//   Selects one storage entry, masks the zero register, and (when REGFILE_BYPASS_EN is
//   defined) forwards same-cycle write data to the reader.
// Ports:
//   rst     in   1                  reset; suppresses bypass while high
//   mem     in   DEPTH x DATA_W     flattened storage array
//   raddr   in   ADDR_W             read address
//   we0/1   in   1                  write enables of the two write ports
//   waddr0/1 in  ADDR_W             write addresses
//   wdata0/1 in  DATA_W             write data
//   rdata   out  DATA_W             read data, 0-cycle latency
// Configuration macro: REGFILE_BYPASS_EN
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 2 ** ADDR_W
) (
  input  logic                          rst,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [ADDR_W-1:0]             raddr,
  input  logic                          we0,
  input  logic [ADDR_W-1:0]             waddr0,
  input  logic [DATA_W-1:0]             wdata0,
  input  logic                          we1,
  input  logic [ADDR_W-1:0]             waddr1,
  input  logic [DATA_W-1:0]             wdata1,
  output logic [DATA_W-1:0]             rdata
);

  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR));

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata = mem[raddr];
    // Port 1 is checked first so a double match forwards wdata1, matching the
    // storage collision rule.
    if (!rst) begin
      if (we1 && (waddr1 == raddr)) begin
        rdata = wdata1;
      end else if (we0 && (waddr0 == raddr)) begin
        rdata = wdata0;
      end
    end
    // Masking last keeps the zero register at 0 even when a write to it is forwarded.
    if (is_zero) begin
      rdata = '0;
    end
  end
`else
  // Without forwarding the write-side inputs are intentionally ignored.
  logic unused_wr;
  assign unused_wr = ^{rst, we0, waddr0, wdata0, we1, waddr1, wdata1};

  always_comb begin
    rdata = mem[raddr];
    if (is_zero) begin
      rdata = '0;
    end
  end
`endif

endmodule

// File: rtl/regfile_2w2r.sv
// rtl/regfile_2w2r.sv - parametrised register file, 2 sync write ports, 2 async read ports
//
// Purpose:
//   Holds the storage array and the write/collision logic; reads go through two
//   regfile_read_port instances. Async active-high reset clears every entry.
// Ports:
//   clk              in   1       write clock (rising edge)
//   rst              in   1       asynchronous active-high reset
//   raddr1/raddr2    in   ADDR_W  read addresses
//   rdata1/rdata2    out  DATA_W  combinational read data
//   we0/waddr0/wdata0 in          write port 0
//   we1/waddr1/wdata1 in          write port 1 (wins on same-address collision)
// Configuration macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding)
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wreq_t;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  wreq_t wr0, wr1;
  logic  do_wr0, do_wr1;

  assign wr0 = '{we: we0, waddr: waddr0, wdata: wdata0};
  assign wr1 = '{we: we1, waddr: waddr1, wdata: wdata1};

  // Writes to the zero register are dropped so it never leaves its reset value.
  assign do_wr0 = wr0.we && !((ZERO_REG != 0) && (wr0.waddr == ADDR_W'(ZERO_ADDR)));
  assign do_wr1 = wr1.we && !((ZERO_REG != 0) && (wr1.waddr == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      // Port 1 is assigned after port 0, so on an address collision its value lands.
      if (do_wr0) begin
        mem[wr0.waddr] <= wr0.wdata;
      end
      if (do_wr1) begin
        mem[wr1.waddr] <= wr1.wdata;
      end
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_rd1 (
    .rst    (rst),
    .mem    (mem),
    .raddr  (raddr1),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .rdata  (rdata1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH)
  ) u_rd2 (
    .rst    (rst),
    .mem    (mem),
    .raddr  (raddr2),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .rdata  (rdata2)
  );

endmodule
